// File: rtl/stream_demux_12_if.sv
// Stream bundle for the 1-to-2 packet demultiplexer: one input stream,
// two output streams and the per-output delivered-packet counters.
interface stream_demux_12_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic             sel;
  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] pkt_cnt0;
  logic [CNT_W-1:0] pkt_cnt1;

  // Source/sink side: drives the input stream and the output readies
  modport master (
    output in_data, in_last, in_valid, sel, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_last, out0_valid,
           out1_data, out1_last, out1_valid, pkt_cnt0, pkt_cnt1
  );

  // Demultiplexer side
  modport slave (
    input  in_data, in_last, in_valid, sel, out0_ready, out1_ready,
    output in_ready, out0_data, out0_last, out0_valid,
           out1_data, out1_last, out1_valid, pkt_cnt0, pkt_cnt1
  );
endinterface

// File: rtl/stream_demux_12.sv
// Registered 1-to-2 stream demultiplexer. The destination is taken from
// sel on the first beat of a packet and held until the last beat. Each
// output has a one-entry register and a wrapping delivered-packet counter.
module stream_demux_12 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  stream_demux_12_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out0_data;
  logic             r_out0_last;
  logic             r_out0_valid;
  logic [WIDTH-1:0] r_out1_data;
  logic             r_out1_last;
  logic             r_out1_valid;
  logic [CNT_W-1:0] r_pkt_cnt0;
  logic [CNT_W-1:0] r_pkt_cnt1;

  logic w_target;
  logic w_in_ready;
  logic w_accept;
  logic w_load0;
  logic w_load1;
  logic w_drain0;
  logic w_drain1;

  // Target selection and handshake: only the target output's fullness matters
  always_comb begin
    w_target = 1'b0;
    case (r_state)
      ST_IDLE:  w_target = io_bus.sel;
      ST_LOCK0: w_target = 1'b0;
      ST_LOCK1: w_target = 1'b1;
      default:  w_target = io_bus.sel;
    endcase
    if (w_target) begin
      w_in_ready = rst_n & (~r_out1_valid | io_bus.out1_ready);
    end else begin
      w_in_ready = rst_n & (~r_out0_valid | io_bus.out0_ready);
    end
    w_accept = io_bus.in_valid & w_in_ready;
    w_load0  = w_accept & ~w_target;
    w_load1  = w_accept & w_target;
    w_drain0 = r_out0_valid & io_bus.out0_ready;
    w_drain1 = r_out1_valid & io_bus.out1_ready;
  end

  // Packet lock FSM: lock onto sel at a multi-beat first beat, release on last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !io_bus.in_last) begin
            r_state <= io_bus.sel ? ST_LOCK1 : ST_LOCK0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOCK0, ST_LOCK1: begin
          if (w_accept && io_bus.in_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= r_state;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register 0: reload wins over drain so drain+reload keeps valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out0_data  <= {WIDTH{1'b0}};
      r_out0_last  <= 1'b0;
      r_out0_valid <= 1'b0;
    end else if (w_load0) begin
      r_out0_data  <= io_bus.in_data;
      r_out0_last  <= io_bus.in_last;
      r_out0_valid <= 1'b1;
    end else if (w_drain0) begin
      r_out0_valid <= 1'b0;
    end
  end

  // Output register 1: same behaviour as output 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out1_data  <= {WIDTH{1'b0}};
      r_out1_last  <= 1'b0;
      r_out1_valid <= 1'b0;
    end else if (w_load1) begin
      r_out1_data  <= io_bus.in_data;
      r_out1_last  <= io_bus.in_last;
      r_out1_valid <= 1'b1;
    end else if (w_drain1) begin
      r_out1_valid <= 1'b0;
    end
  end

  // Delivered-packet counters: count last beats leaving each output, wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt0 <= {CNT_W{1'b0}};
      r_pkt_cnt1 <= {CNT_W{1'b0}};
    end else begin
      if (w_drain0 && r_out0_last) begin
        r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
      end
      if (w_drain1 && r_out1_last) begin
        r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
      end
    end
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.out0_data  = r_out0_data;
  assign io_bus.out0_last  = r_out0_last;
  assign io_bus.out0_valid = r_out0_valid;
  assign io_bus.out1_data  = r_out1_data;
  assign io_bus.out1_last  = r_out1_last;
  assign io_bus.out1_valid = r_out1_valid;
  assign io_bus.pkt_cnt0   = r_pkt_cnt0;
  assign io_bus.pkt_cnt1   = r_pkt_cnt1;

endmodule

// File: tb/tb_stream_demux_12.sv
// Directed bench for stream_demux_12 (CNT_W = 4 so the counter wrap is reachable).
module tb_stream_demux_12;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  stream_demux_12_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc ();

  stream_demux_12 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rdy_pat;
    logic        acc;
    logic        drn;
    logic [7:0]  dd;
    int          idx;
    int          rx;

    checks = 0;
    failures = 0;
    rdy_pat = 32'b1011_0010_1110_0110_1101_0011_1111_1001;
    rst_n = 1'b0;
    ifc.in_data = 8'h00;
    ifc.in_last = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.sel = 1'b0;
    ifc.out0_ready = 1'b0;
    ifc.out1_ready = 1'b0;
    tick();
    tick();
    chk("rst_out0_valid", 32'(ifc.out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(ifc.out1_valid), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_cnt0", 32'(ifc.pkt_cnt0), 32'd0);
    rst_n = 1'b1;

    // ---- Reset check: mid-packet asynchronous reset with out0 full
    ifc.in_valid = 1'b1; ifc.sel = 1'b0; ifc.in_data = 8'h3C; ifc.in_last = 1'b0;
    tick();
    chk("pre_rst_out0_valid", 32'(ifc.out0_valid), 32'd1);
    chk("pre_rst_out0_data", 32'(ifc.out0_data), 32'h3C);
    ifc.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_out0_valid", 32'(ifc.out0_valid), 32'd0);
    chk("async_out0_data", 32'(ifc.out0_data), 32'd0);
    chk("async_in_ready", 32'(ifc.in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    ifc.in_valid = 1'b1; ifc.sel = 1'b1; ifc.in_data = 8'hA5; ifc.in_last = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);
    tick();
    chk("post_rst_out1_valid", 32'(ifc.out1_valid), 32'd1);
    chk("post_rst_out1_data", 32'(ifc.out1_data), 32'hA5);
    chk("post_rst_out0_valid", 32'(ifc.out0_valid), 32'd0);
    ifc.in_valid = 1'b0; ifc.out1_ready = 1'b1;
    tick();
    chk("post_rst_drain", 32'(ifc.out1_valid), 32'd0);
    chk("post_rst_cnt1", 32'(ifc.pkt_cnt1), 32'd1);

    // ---- Packet lock: sel toggles after the first beat
    ifc.out0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1'b1;
      ifc.sel = (i == 0) ? 1'b0 : 1'b1;
      ifc.in_data = 8'(8'h10 + i);
      ifc.in_last = (i == 3);
      #1;
      chk("lock_in_ready", 32'(ifc.in_ready), 32'd1);
      tick();
      chk("lock_out0_valid", 32'(ifc.out0_valid), 32'd1);
      chk("lock_out0_data", 32'(ifc.out0_data), 32'(8'h10 + i));
      chk("lock_out0_last", 32'(ifc.out0_last), 32'(i == 3));
      chk("lock_out1_valid", 32'(ifc.out1_valid), 32'd0);
    end
    ifc.in_valid = 1'b0;
    tick();
    chk("lock_cnt0", 32'(ifc.pkt_cnt0), 32'd1);
    chk("lock_cnt1", 32'(ifc.pkt_cnt1), 32'd1);

    // ---- Stall isolation: out0 held full, traffic to out1 still flows
    ifc.out0_ready = 1'b0;
    ifc.in_valid = 1'b1; ifc.sel = 1'b0; ifc.in_data = 8'h55; ifc.in_last = 1'b1;
    tick();
    chk("stall_out0_data", 32'(ifc.out0_data), 32'h55);
    ifc.in_data = 8'h77;
    #1;
    chk("stall_in_ready_t0", 32'(ifc.in_ready), 32'd0);
    tick();
    chk("stall_out0_hold", 32'(ifc.out0_data), 32'h55);
    ifc.sel = 1'b1; ifc.in_data = 8'h66; ifc.in_last = 1'b0;
    #1;
    chk("stall_in_ready_t1a", 32'(ifc.in_ready), 32'd1);
    tick();
    chk("stall_out1_data_a", 32'(ifc.out1_data), 32'h66);
    ifc.sel = 1'b0; ifc.in_data = 8'h67; ifc.in_last = 1'b1;
    #1;
    chk("stall_in_ready_t1b", 32'(ifc.in_ready), 32'd1);
    tick();
    chk("stall_out1_data_b", 32'(ifc.out1_data), 32'h67);
    chk("stall_out1_last_b", 32'(ifc.out1_last), 32'd1);
    chk("stall_out0_keep", 32'(ifc.out0_data), 32'h55);
    chk("stall_out0_valid", 32'(ifc.out0_valid), 32'd1);
    ifc.in_valid = 1'b0;
    tick();
    chk("stall_cnt1", 32'(ifc.pkt_cnt1), 32'd2);
    chk("stall_out0_still", 32'(ifc.out0_valid), 32'd1);
    ifc.out0_ready = 1'b1;
    tick();
    chk("stall_cnt0", 32'(ifc.pkt_cnt0), 32'd2);
    chk("stall_out0_empty", 32'(ifc.out0_valid), 32'd0);

    // ---- Backpressure on out1 across a 16-beat packet
    idx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 64 && rx < 16; cyc++) begin
      ifc.out1_ready = rdy_pat[cyc % 32];
      if (idx < 16) begin
        ifc.in_valid = 1'b1;
        ifc.sel = 1'b1;
        ifc.in_data = 8'(8'h80 + idx);
        ifc.in_last = (idx == 15);
      end else begin
        ifc.in_valid = 1'b0;
      end
      #1;
      if (ifc.out1_ready && ifc.out1_valid) chk("bp_sustain", 32'(ifc.in_ready), 32'd1);
      acc = ifc.in_valid & ifc.in_ready;
      drn = ifc.out1_valid & ifc.out1_ready;
      dd = ifc.out1_data;
      tick();
      if (acc) idx++;
      if (drn) begin
        chk("bp_order", 32'(dd), 32'(8'h80 + rx));
        rx++;
      end
    end
    chk("bp_rx_count", 32'(rx), 32'd16);
    chk("bp_tx_count", 32'(idx), 32'd16);
    chk("bp_cnt1", 32'(ifc.pkt_cnt1), 32'd3);
    chk("bp_out0_idle", 32'(ifc.out0_valid), 32'd0);

    // ---- Alternating single-beat packets, no bubbles
    do_reset();
    ifc.out0_ready = 1'b1; ifc.out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1'b1;
      ifc.sel = i[0];
      ifc.in_data = 8'(8'hC0 + i);
      ifc.in_last = 1'b1;
      #1;
      chk("alt_in_ready", 32'(ifc.in_ready), 32'd1);
      tick();
      if (i[0]) begin
        chk("alt_out1_valid", 32'(ifc.out1_valid), 32'd1);
        chk("alt_out1_data", 32'(ifc.out1_data), 32'(8'hC0 + i));
      end else begin
        chk("alt_out0_valid", 32'(ifc.out0_valid), 32'd1);
        chk("alt_out0_data", 32'(ifc.out0_data), 32'(8'hC0 + i));
      end
    end
    ifc.in_valid = 1'b0;
    tick();
    chk("alt_cnt0", 32'(ifc.pkt_cnt0), 32'd2);
    chk("alt_cnt1", 32'(ifc.pkt_cnt1), 32'd2);

    // ---- Counter wrap: 17 single-beat packets to out0 with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) begin
      ifc.in_valid = 1'b1;
      ifc.sel = 1'b0;
      ifc.in_data = 8'(i);
      ifc.in_last = 1'b1;
      tick();
    end
    ifc.in_valid = 1'b0;
    tick();
    chk("wrap_cnt0", 32'(ifc.pkt_cnt0), 32'd1);
    chk("wrap_cnt1", 32'(ifc.pkt_cnt1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
